cacheline_adaptor: RTL and testbench



---
 rtl/cacheline_adaptor_pkg.sv | 22 ++
 rtl/cacheline_adaptor_if.sv | 29 ++
 rtl/cacheline_adaptor.sv | 91 +++++++++
 tb/tb_cacheline_adaptor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants, types and state encoding for the cache-line / memory-burst adaptor.
package cacheline_adaptor_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W       = $clog2(BEATS);
    localparam int BEAT_LSB_W  = $clog2(BURST_WIDTH);
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

    typedef logic [LINE_WIDTH-1:0]  cacheline_t;
    typedef logic [BURST_WIDTH-1:0] burst_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DONE = 3'd2,
        WR      = 3'd3,
        WR_DONE = 3'd4
    } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line signals and memory-side burst signals of the adaptor.
interface cacheline_adaptor_if;
    import cacheline_adaptor_pkg::*;

    cacheline_t  line_i;
    cacheline_t  line_o;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic        resp_o;
    burst_t      burst_i;
    burst_t      burst_o;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic        resp_i;

    // The adaptor is the slave; the cache/memory environment is the master.
    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit line fills/writebacks into 4-beat 64-bit memory bursts.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    cacheline_adaptor_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    cla_state_t               state;
    cla_state_t               state_next;
    logic [CNT_W-1:0]         count;
    logic [31:0]              addr_q;
    cacheline_t               rd_line;
    cacheline_t               wr_line;
    logic [$clog2(LINE_WIDTH)-1:0] beat_base;

    assign beat_base = {count, {BEAT_LSB_W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.write_i) begin
                    state_next = WR;
                end else if (bus.read_i) begin
                    state_next = RD;
                end
            end
            RD:      if (bus.resp_i && count == LAST_BEAT) state_next = RD_DONE;
            RD_DONE: state_next = IDLE;
            WR:      if (bus.resp_i && count == LAST_BEAT) state_next = WR_DONE;
            WR_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address and write line are captured only on accept, so they stay stable for the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            addr_q  <= '0;
            rd_line <= '0;
            wr_line <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.write_i || bus.read_i) begin
                        addr_q <= {bus.address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        count  <= '0;
                    end
                    if (bus.write_i) begin
                        wr_line <= bus.line_i;
                    end
                end
                RD: begin
                    if (bus.resp_i) begin
                        rd_line[beat_base +: BURST_WIDTH] <= bus.burst_i;
                        count <= count + 1'b1;
                    end
                end
                WR: begin
                    if (bus.resp_i) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.read_o    = (state == RD);
        bus.write_o   = (state == WR);
        bus.resp_o    = (state == RD_DONE) || (state == WR_DONE);
        bus.burst_o   = (state == WR) ? wr_line[beat_base +: BURST_WIDTH] : '0;
        bus.line_o    = rd_line;
        bus.address_o = addr_q;
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    cacheline_adaptor_if bus ();

    cacheline_adaptor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    burst_t rb [4];
    burst_t gb [4];
    burst_t wb [4];
    burst_t bb [4];
    int     gpat [7];
    int     wpat [6];
    int     k;
    cacheline_t wline;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rb[0] = {4{16'h1111}}; rb[1] = {4{16'h2222}}; rb[2] = {4{16'h3333}}; rb[3] = {4{16'h4444}};
        gb[0] = 64'h0123_4567_89AB_CDEF; gb[1] = 64'hFEDC_BA98_7654_3210;
        gb[2] = 64'hDEAD_BEEF_CAFE_F00D; gb[3] = 64'h0F0F_0F0F_F0F0_F0F0;
        wb[0] = {4{16'hAAAA}}; wb[1] = {4{16'hBBBB}}; wb[2] = {4{16'hCCCC}}; wb[3] = {4{16'hDDDD}};
        bb[0] = {4{16'h5555}}; bb[1] = {4{16'h6666}}; bb[2] = {4{16'h7777}}; bb[3] = {4{16'h8888}};
        gpat = '{1, 0, 0, 1, 1, 0, 1};
        wpat = '{0, 1, 1, 0, 1, 1};

        bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
        bus.burst_i = '0; bus.resp_i = 1'b0;
        rst_n = 1'b0;
        #12;
        check_eq("rst_read_o", bus.read_o, 0);
        check_eq("rst_write_o", bus.write_o, 0);
        check_eq("rst_resp_o", bus.resp_o, 0);
        check_eq("rst_line_o", bus.line_o, 0);
        check_eq("rst_address_o", bus.address_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Zero-wait read
        bus.address_i = 32'h0000_1234;
        bus.read_i = 1'b1;
        tick();
        bus.read_i = 1'b0;
        check_eq("zr_address_o", bus.address_o, 32'h0000_1220);
        for (int i = 0; i < 4; i++) begin
            check_eq("zr_read_o", bus.read_o, 1);
            check_eq("zr_resp_o_early", bus.resp_o, 0);
            bus.burst_i = rb[i];
            bus.resp_i = 1'b1;
            tick();
        end
        bus.resp_i = 1'b0;
        check_eq("zr_resp_o", bus.resp_o, 1);
        check_eq("zr_read_o_drop", bus.read_o, 0);
        check_eq("zr_line_o", bus.line_o, {rb[3], rb[2], rb[1], rb[0]});
        tick();
        check_eq("zr_resp_o_single", bus.resp_o, 0);

        // Gapped read
        bus.address_i = 32'h8000_003F;
        bus.read_i = 1'b1;
        tick();
        bus.read_i = 1'b0;
        check_eq("gr_address_o", bus.address_o, 32'h8000_0020);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            check_eq("gr_read_o", bus.read_o, 1);
            check_eq("gr_resp_o_early", bus.resp_o, 0);
            bus.resp_i = (gpat[i] != 0);
            bus.burst_i = (gpat[i] != 0) ? gb[k] : 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
            if (gpat[i] != 0) k++;
        end
        bus.resp_i = 1'b0;
        check_eq("gr_resp_o", bus.resp_o, 1);
        check_eq("gr_read_o_drop", bus.read_o, 0);
        check_eq("gr_line_o", bus.line_o, {gb[3], gb[2], gb[1], gb[0]});
        tick();
        check_eq("gr_resp_o_single", bus.resp_o, 0);

        // Write with simultaneous read request; write wins, inputs change mid-burst
        wline = {wb[3], wb[2], wb[1], wb[0]};
        bus.line_i = wline;
        bus.address_i = 32'h0000_ABCD;
        bus.write_i = 1'b1;
        bus.read_i = 1'b1;
        tick();
        bus.write_i = 1'b0;
        bus.line_i = {4{64'h9999_9999_9999_9999}};
        bus.address_i = 32'hFFFF_FFFF;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            check_eq("wr_write_o", bus.write_o, 1);
            check_eq("wr_read_o", bus.read_o, 0);
            check_eq("wr_burst_o", bus.burst_o, wb[k]);
            check_eq("wr_address_o", bus.address_o, 32'h0000_ABC0);
            bus.resp_i = (wpat[i] != 0);
            tick();
            bus.read_i = 1'b0;
            if (wpat[i] != 0) k++;
        end
        bus.resp_i = 1'b0;
        check_eq("wr_resp_o", bus.resp_o, 1);
        check_eq("wr_write_o_drop", bus.write_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("wr_no_extra_resp", bus.resp_o, 0);
            check_eq("wr_idle_write_o", bus.write_o, 0);
        end
        check_eq("wr_line_o_kept", bus.line_o, {gb[3], gb[2], gb[1], gb[0]});

        // Back-to-back read then write
        bus.address_i = 32'h0000_0040;
        bus.read_i = 1'b1;
        tick();
        bus.read_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.burst_i = bb[i];
            bus.resp_i = 1'b1;
            tick();
        end
        bus.resp_i = 1'b0;
        check_eq("bb_resp_o", bus.resp_o, 1);
        tick();
        check_eq("bb_idle_resp_o", bus.resp_o, 0);
        bus.write_i = 1'b1;
        bus.line_i = wline;
        bus.address_i = 32'h0000_0060;
        tick();
        bus.write_i = 1'b0;
        check_eq("bb_write_o", bus.write_o, 1);
        check_eq("bb_address_o", bus.address_o, 32'h0000_0060);
        check_eq("bb_line_o", bus.line_o, {bb[3], bb[2], bb[1], bb[0]});
        for (int i = 0; i < 4; i++) begin
            check_eq("bb_burst_o", bus.burst_o, wb[i]);
            bus.resp_i = 1'b1;
            tick();
        end
        bus.resp_i = 1'b0;
        check_eq("bb_wr_resp_o", bus.resp_o, 1);
        check_eq("bb_line_o_after_wr", bus.line_o, {bb[3], bb[2], bb[1], bb[0]});
        tick();

        // Asynchronous reset in the middle of a write burst (count=2)
        bus.write_i = 1'b1;
        bus.line_i = wline;
        bus.address_i = 32'h0000_1000;
        tick();
        bus.write_i = 1'b0;
        bus.resp_i = 1'b1;
        tick();
        tick();
        bus.resp_i = 1'b0;
        check_eq("ar_burst_o_beat2", bus.burst_o, wb[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_write_o", bus.write_o, 0);
        check_eq("ar_read_o", bus.read_o, 0);
        check_eq("ar_resp_o", bus.resp_o, 0);
        check_eq("ar_burst_o", bus.burst_o, 0);
        check_eq("ar_address_o", bus.address_o, 0);
        check_eq("ar_line_o", bus.line_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.resp_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("ar_post_resp_o", bus.resp_o, 0);
            check_eq("ar_post_write_o", bus.write_o, 0);
        end
        bus.resp_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
